// File: rtl/mont_mult_unit.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*2^-WIDTH mod m, one bit of a per clock.
// Latency WIDTH+2 cycles from accepted start to done (2 on rejected operands); start ignored while busy.
// Optional operand check under macro MONT_MULT_OPCHECK_EN; without it err is tied low.
module mont_mult_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] m_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam int PW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        CORR = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] m_q;
    logic [PW-1:0]    p_q;
    logic [PW-1:0]    t_sum;
    logic [PW-1:0]    u_sum;
    logic [PW-1:0]    p_step;
    logic [WIDTH-1:0] result_corr;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             bad_ops;

`ifdef MONT_MULT_OPCHECK_EN
    logic bad_q;
    logic err_q;
    assign bad_ops = ~m_in[0] | (a_in >= m_in) | (b_in >= m_in);
    assign err     = err_q;
`else
    assign bad_ops = 1'b0;
    assign err     = 1'b0;
`endif

    assign busy     = (state != IDLE);
    assign last_bit = (cnt == CW'(WIDTH - 1));

    // a_q is shifted right each iteration, so its LSB is always the current bit.
    always_comb begin
        t_sum       = p_q + (a_q[0] ? {2'b00, b_q} : '0);
        u_sum       = t_sum + (t_sum[0] ? {2'b00, m_q} : '0);
        p_step      = u_sum >> 1;
        result_corr = (p_q >= {2'b00, m_q}) ? WIDTH'(p_q - {2'b00, m_q}) : p_q[WIDTH-1:0];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = bad_ops ? CORR : CALC;
            CALC:    if (last_bit) state_next = CORR;
            CORR:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            m_q    <= '0;
            p_q    <= '0;
            cnt    <= '0;
            done   <= 1'b0;
            result <= '0;
`ifdef MONT_MULT_OPCHECK_EN
            bad_q  <= 1'b0;
            err_q  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a_in;
                        b_q   <= b_in;
                        m_q   <= m_in;
                        p_q   <= '0;
                        cnt   <= '0;
`ifdef MONT_MULT_OPCHECK_EN
                        bad_q <= bad_ops;
                        err_q <= 1'b0;
`endif
                    end
                end
                CALC: begin
                    p_q <= p_step;
                    a_q <= a_q >> 1;
                    cnt <= cnt + 1'b1;
                end
                CORR: begin
                    done <= 1'b1;
`ifdef MONT_MULT_OPCHECK_EN
                    if (bad_q) begin
                        result <= '0;
                        err_q  <= 1'b1;
                    end else begin
                        result <= result_corr;
                    end
`else
                    result <= result_corr;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
